phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Parametrised instruction-phase sequencer for the RISC core: steps an encoded phase register through `NUM_PHASES` phases (FETCH, DECODE, EXECUTE, UPDATE at default size) and wraps. Each phase can be held for a programmable number of enabled cycles. The block also supports a direct phase load, halting at an instruction boundary, and an optional instruction-cycle counter. It drives the core's control unit and replaces the fixed one-cycle-per-phase generator.

## Interface
- `NUM_PHASES`, 4: phase count, ≥2.
- `PHASE_W`, `$clog2(NUM_PHASES)`: phase encoding width.
- `DWELL_W`, 3: dwell-table entry width.
- `CNT_W`, 16: cycle-counter width.

Ports:
- `CLK` in 1: clock, all state on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `ENA` in 1: active-low enable; 0 lets the sequencer count and advance.
- `HALT_REQ` in 1: level request to stop at the next wrap to phase 0.
- `LOAD_EN` in 1: force phase load.
- `LOAD_PHASE` in `PHASE_W`: target phase for load.
- `CFG_WE` in 1: dwell-table write strobe.
- `CFG_IDX` in `PHASE_W`: table entry index.
- `CFG_DWELL` in `DWELL_W`: entry value; phase lasts value+1 enabled cycles.
- `PHASE` out `PHASE_W`: current phase, encoded.
- `PHASE_OH` out `NUM_PHASES`: one-hot of `PHASE`.
- `FIRST` out 1: first cycle of the current phase (dwell count = 0).
- `WRAP` out 1: the final phase advances to 0 at the coming edge.
- `HALTED` out 1: sequencer frozen at phase 0.
- `CYC_CNT` out `CNT_W`: completed instruction cycles.

## Operation
- **State:** `PHASE`, dwell count `DCNT` (`DWELL_W` bits), `HALTED`, dwell table `NUM_PHASES`×`DWELL_W`, and `CYC_CNT`.
- **Reset:** `PHASE`=0, `DCNT`=0, `HALTED`=0, all table entries 0, `CYC_CNT`=0. The resulting outputs are `PHASE_OH`=0001, `FIRST`=1, `WRAP`=0.
- **Advance condition:** `adv` = !`ENA` & !`HALTED` & (`DCNT` ≥ table[`PHASE`]).
  - When `adv`: `PHASE` goes to `PHASE`+1, or to 0 if `PHASE`=`NUM_PHASES`-1. `DCNT` goes to 0.
  - When !`ENA` & !`HALTED` & !`adv`: `DCNT`+1.
  - When `ENA`=1 or `HALTED`: everything holds.
- **Wrap:** `WRAP` = `adv` & (`PHASE`=`NUM_PHASES`-1). It is combinational. On a wrap, `CYC_CNT` increments modulo 2^`CNT_W`.
- **Halt:** a wrap with `HALT_REQ`=1 sets `HALTED`. `HALTED` clears on the first edge that sees `HALT_REQ`=0, and advancing resumes in the following cycle. `HALT_REQ` never stops the sequencer mid-instruction.
- **Load:** `LOAD_EN`=1 sets `PHASE`=`LOAD_PHASE` and `DCNT`=0 at the next edge, regardless of `ENA`.
  - Out-of-range `LOAD_PHASE` (≥`NUM_PHASES`) loads 0.
  - A load does not alter `HALTED` and does not count as a wrap.
- **Priority:** `RST` > `LOAD_EN` > advance/count.
- **Config writes:** the entry is written at the edge, so the new value is used from the next cycle. The advance decision in the write cycle uses the old value.
  - Lowering the current phase's entry below `DCNT` causes an advance on the next enabled cycle, because of the ≥ compare.
  - An out-of-range `CFG_IDX` is ignored.

## Timing
- `PHASE`, `DCNT`, `HALTED`, `CYC_CNT` and the table are registered.
- `PHASE_OH` and `FIRST` are decoded combinationally from registers only.
- `WRAP` depends combinationally on `ENA`.
- With all entries 0 and `ENA`=0, the phase changes every cycle, giving a 4-cycle instruction at default size.
- With entry d, the phase occupies d+1 enabled cycles. Cycles with `ENA`=1 stretch the phase without consuming dwell.
- Halt latency: `HALTED`=1 in the cycle after the wrap edge. The request must be asserted during the wrap cycle.
- `RST` asserted mid-phase or mid-halt gives the reset values at the next edge.

## Configuration
- Macro: `PHASE_SEQ_CYC_CNT_EN`.
  - Defined: the `CYC_CNT` register and incrementer are built as described above.
  - Undefined: the `CYC_CNT` port remains but is tied to 0, and no counter flops are synthesised. All other behaviour is identical.

## Structure
- Shared package `risc_pkg` holds:
  - the phase enum type (FETCH=0, DECODE=1, EXECUTE=2, UPDATE=3) for default size;
  - default `NUM_PHASES`, `DWELL_W` and `CNT_W` constants.
- One sub-module, `phase_dwell_table`: register file with write port (`CFG_WE`, `CFG_IDX`, `CFG_DWELL`), one combinational read port indexed by `PHASE`, and synchronous reset to 0.

## Test plan
All scenarios use default parameters.
- **Default run:** reset, then `ENA`=0 for 9 cycles → `PHASE` 0,1,2,3,0,1,2,3,0; `WRAP` high in cycles 4 and 8; `CYC_CNT`=2.
- **Dwell:** write table[2]=3, run → EXECUTE lasts 4 cycles with `FIRST` only in its first cycle. Holding `ENA`=1 for 2 cycles mid-EXECUTE extends it to 6 cycles.
- **Halt:** assert `HALT_REQ` during DECODE → sequencer finishes UPDATE, `PHASE`=0, `HALTED`=1 and frozen for 5 cycles. Deassert → `HALTED`=0 one edge later, then DECODE the cycle after that.
- **Load and priority:** `LOAD_EN`=1, `LOAD_PHASE`=2 with `ENA`=1 → `PHASE`=2, `DCNT`=0. Same cycle as `RST`=1 → `PHASE`=0. `LOAD_PHASE` out of range → `PHASE`=0.
- **Write collision:** during EXECUTE with table[2]=5 and `DCNT`=4, write table[2]=1 → no advance that cycle; advance on the next enabled cycle.
- **Macro build:** compile without `PHASE_SEQ_CYC_CNT_EN`, run 3 instructions → `CYC_CNT` stays 0 and all other outputs match the macro-enabled build.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared RISC core types: instruction phase encoding and default sizes
// for the phase sequencer.
package risc_pkg;

    localparam int DEF_NUM_PHASES = 4;
    localparam int DEF_DWELL_W    = 3;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        UPDATE  = 2'd3
    } phase_e;

endpackage

// File: rtl/phase_dwell_table.sv
// Per-phase dwell register file: one write port, one combinational
// read port, synchronous reset to zero.
module phase_dwell_table
    import risc_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int PHASE_W    = $clog2(NUM_PHASES),
    parameter int DWELL_W    = DEF_DWELL_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic [PHASE_W-1:0] idx_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic [PHASE_W-1:0] rd_idx_i,
    output logic [DWELL_W-1:0] rd_dwell_o
);

    localparam logic [PHASE_W:0] NP = NUM_PHASES[PHASE_W:0];

    logic [DWELL_W-1:0] tbl_q [NUM_PHASES];

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = we_i && ({1'b0, idx_i} < NP);
    assign rd_ok = {1'b0, rd_idx_i} < NP;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (wr_ok) begin
            tbl_q[idx_i] <= dwell_i;
        end
    end

    assign rd_dwell_o = rd_ok ? tbl_q[rd_idx_i] : '0;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer with per-phase dwell, load and halt.
// PHASE_SEQ_CYC_CNT_EN builds the completed-instruction counter.
module phase_sequencer
    import risc_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int PHASE_W    = $clog2(NUM_PHASES),
    parameter int DWELL_W    = DEF_DWELL_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENA,
    input  logic                  HALT_REQ,
    input  logic                  LOAD_EN,
    input  logic [PHASE_W-1:0]    LOAD_PHASE,
    input  logic                  CFG_WE,
    input  logic [PHASE_W-1:0]    CFG_IDX,
    input  logic [DWELL_W-1:0]    CFG_DWELL,
    output logic [PHASE_W-1:0]    PHASE,
    output logic [NUM_PHASES-1:0] PHASE_OH,
    output logic                  FIRST,
    output logic                  WRAP,
    output logic                  HALTED,
    output logic [CNT_W-1:0]      CYC_CNT
);

    localparam logic [PHASE_W:0]   NP      = NUM_PHASES[PHASE_W:0];
    localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(NUM_PHASES - 1);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic               halted_q, halted_d;
    logic [DWELL_W-1:0] dwell;
    logic               run;
    logic               adv;
    logic               last;
    logic               wrap_cnt;

    phase_dwell_table #(
        .NUM_PHASES (NUM_PHASES),
        .PHASE_W    (PHASE_W),
        .DWELL_W    (DWELL_W)
    ) u_tbl (
        .clk_i      (CLK),
        .rst_i      (RST),
        .we_i       (CFG_WE),
        .idx_i      (CFG_IDX),
        .dwell_i    (CFG_DWELL),
        .rd_idx_i   (phase_q),
        .rd_dwell_o (dwell)
    );

    assign run  = !ENA && !halted_q;
    assign adv  = run && (dcnt_q >= dwell);
    assign last = (phase_q == LAST_PH);
    assign WRAP = adv && last;
    // A load overrides the advance, so it is never a completed instruction.
    assign wrap_cnt = WRAP && !LOAD_EN;

    always_comb begin
        phase_d  = phase_q;
        dcnt_d   = dcnt_q;
        halted_d = halted_q;
        if (LOAD_EN) begin
            phase_d = ({1'b0, LOAD_PHASE} < NP) ? LOAD_PHASE : '0;
            dcnt_d  = '0;
        end else if (adv) begin
            phase_d = last ? '0 : phase_q + 1'b1;
            dcnt_d  = '0;
        end else if (run) begin
            dcnt_d = dcnt_q + 1'b1;
        end
        if (halted_q) begin
            halted_d = HALT_REQ;
        end else if (wrap_cnt && HALT_REQ) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q  <= '0;
            dcnt_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            dcnt_q   <= dcnt_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        PHASE_OH = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            PHASE_OH[i] = (phase_q == PHASE_W'(i));
        end
    end

    assign PHASE  = phase_q;
    assign FIRST  = (dcnt_q == '0);
    assign HALTED = halted_q;

`ifdef PHASE_SEQ_CYC_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wrap_cnt) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CYC_CNT = cnt_q;
`else
    assign CYC_CNT = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer at default size: run, dwell,
// stretch, halt, load/priority and config-write collision.
module tb_phase_sequencer;
    import risc_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENA;
    logic        HALT_REQ;
    logic        LOAD_EN;
    logic [1:0]  LOAD_PHASE;
    logic        CFG_WE;
    logic [1:0]  CFG_IDX;
    logic [2:0]  CFG_DWELL;
    logic [1:0]  PHASE;
    logic [3:0]  PHASE_OH;
    logic        FIRST;
    logic        WRAP;
    logic        HALTED;
    logic [15:0] CYC_CNT;

    int vec  = 0;
    int miss = 0;

    int exp_ph[9]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int exp_wr[9]  = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    int ena_pat[6] = '{0, 1, 1, 0, 0, 0};

    phase_sequencer dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENA        (ENA),
        .HALT_REQ   (HALT_REQ),
        .LOAD_EN    (LOAD_EN),
        .LOAD_PHASE (LOAD_PHASE),
        .CFG_WE     (CFG_WE),
        .CFG_IDX    (CFG_IDX),
        .CFG_DWELL  (CFG_DWELL),
        .PHASE      (PHASE),
        .PHASE_OH   (PHASE_OH),
        .FIRST      (FIRST),
        .WRAP       (WRAP),
        .HALTED     (HALTED),
        .CYC_CNT    (CYC_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic int ec(input int n);
        int r;
        r = n;
`ifndef PHASE_SEQ_CYC_CNT_EN
        r = 0;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [2:0] val);
        CFG_WE    = 1'b1;
        CFG_IDX   = idx;
        CFG_DWELL = val;
        tick();
        CFG_WE    = 1'b0;
    endtask

    initial begin
        RST = 1'b1; ENA = 1'b1; HALT_REQ = 1'b0; LOAD_EN = 1'b0;
        LOAD_PHASE = 2'd0; CFG_WE = 1'b0; CFG_IDX = 2'd0; CFG_DWELL = 3'd0;
        tick();
        tick();
        RST = 1'b0;
        ENA = 1'b0;
        #1;
        chk("rst_phase", 32'(PHASE), 0);
        chk("rst_oh", 32'(PHASE_OH), 32'h1);
        chk("rst_first", 32'(FIRST), 1);
        chk("rst_wrap", 32'(WRAP), 0);
        chk("rst_halted", 32'(HALTED), 0);
        chk("rst_cnt", 32'(CYC_CNT), 0);

        for (int i = 0; i < 9; i++) begin
            #1;
            chk("run_phase", 32'(PHASE), exp_ph[i]);
            chk("run_wrap", 32'(WRAP), exp_wr[i]);
            tick();
        end
        #1;
        chk("run_cnt", 32'(CYC_CNT), ec(2));
        chk("run_end", 32'(PHASE), 1);

        ENA = 1'b1;
        cfg(2'd2, 3'd3);
        ENA = 1'b0;
        #1;
        chk("dw_pre", 32'(PHASE), 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("dw_phase", 32'(PHASE), EXECUTE);
            chk("dw_first", 32'(FIRST), (k == 0) ? 1 : 0);
            tick();
        end
        #1;
        chk("dw_next", 32'(PHASE), UPDATE);
        tick();
        tick();
        tick();
        #1;
        chk("st_first", 32'(FIRST), 1);
        for (int k = 0; k < 6; k++) begin
            ENA = (ena_pat[k] != 0);
            #1;
            chk("st_phase", 32'(PHASE), EXECUTE);
            tick();
        end
        ENA = 1'b1;
        #1;
        chk("st_next", 32'(PHASE), UPDATE);
        chk("wrap_ena_hi", 32'(WRAP), 0);
        ENA = 1'b0;
        #1;
        chk("wrap_ena_lo", 32'(WRAP), 1);

        CFG_WE = 1'b1; CFG_IDX = 2'd2; CFG_DWELL = 3'd0;
        tick();
        CFG_WE = 1'b0;
        tick();
        HALT_REQ = 1'b1;
        #1;
        chk("h_decode", 32'(PHASE), DECODE);
        tick();
        tick();
        #1;
        chk("h_wrap", 32'(WRAP), 1);
        chk("h_not_yet", 32'(HALTED), 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("h_phase", 32'(PHASE), FETCH);
            chk("h_halted", 32'(HALTED), 1);
            chk("h_wrap0", 32'(WRAP), 0);
            tick();
        end
        #1;
        chk("h_cnt", 32'(CYC_CNT), ec(5));
        HALT_REQ = 1'b0;
        #1;
        chk("h_still", 32'(HALTED), 1);
        tick();
        #1;
        chk("h_clear", 32'(HALTED), 0);
        chk("h_clear_ph", 32'(PHASE), FETCH);
        tick();
        #1;
        chk("h_resume", 32'(PHASE), DECODE);

        ENA = 1'b1;
        cfg(2'd3, 3'd3);
        ENA = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk("ld_pre_ph", 32'(PHASE), UPDATE);
        chk("ld_pre_first", 32'(FIRST), 0);
        ENA = 1'b1; LOAD_EN = 1'b1; LOAD_PHASE = 2'd2;
        tick();
        LOAD_EN = 1'b0;
        #1;
        chk("ld_phase", 32'(PHASE), EXECUTE);
        chk("ld_first", 32'(FIRST), 1);
        LOAD_EN = 1'b1; LOAD_PHASE = 2'd3; RST = 1'b1;
        tick();
        LOAD_EN = 1'b0; RST = 1'b0;
        #1;
        chk("pri_phase", 32'(PHASE), FETCH);
        chk("pri_oh", 32'(PHASE_OH), 32'h1);
        chk("pri_cnt", 32'(CYC_CNT), 0);
        chk("pri_halted", 32'(HALTED), 0);

        cfg(2'd2, 3'd5);
        LOAD_EN = 1'b1; LOAD_PHASE = 2'd2;
        tick();
        LOAD_EN = 1'b0;
        ENA = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        #1;
        chk("col_pre", 32'(PHASE), EXECUTE);
        chk("col_first", 32'(FIRST), 0);
        cfg(2'd2, 3'd1);
        #1;
        chk("col_hold", 32'(PHASE), EXECUTE);
        chk("col_wrap", 32'(WRAP), 0);
        tick();
        #1;
        chk("col_adv", 32'(PHASE), UPDATE);
        chk("col_oh", 32'(PHASE_OH), 32'h8);
        chk("col_wrap1", 32'(WRAP), 1);
        tick();
        #1;
        chk("end_phase", 32'(PHASE), FETCH);
        chk("end_cnt", 32'(CYC_CNT), ec(1));

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
